// File: rtl/div_18x9_signed_seq.sv
// Iterative signed divider: radix-2 restoring division on magnitudes with final sign fix.
// Runtime appr_lsb skips low-order quotient iterations, trading accuracy for latency.
module div_18x9_signed_seq #(
  parameter int DIV_IN_WIDTH  = 9,
  parameter int DIV_OUT_WIDTH = DIV_IN_WIDTH*2,
  parameter int N_BIT_APPR    = 4,
  parameter int MAX_APPR      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIV_OUT_WIDTH-1:0] dividend,
  input  logic [DIV_IN_WIDTH-1:0]  divisor,
  input  logic [N_BIT_APPR-1:0]    appr_lsb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIV_OUT_WIDTH-1:0] quotient,
  output logic [DIV_IN_WIDTH-1:0]  remainder,
  output logic                     dbz,
  output logic                     approx
);
  localparam int OW = DIV_OUT_WIDTH;
  localparam int IW = DIV_IN_WIDTH;
  localparam int CW = $clog2(OW+1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         xsr_q, xsr_d;
  logic [OW-1:0]         qr_q, qr_d;
  logic [IW-1:0]         dmag_q, dmag_d;
  logic [IW:0]           r_q, r_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N_BIT_APPR-1:0] k_q, k_d;
  logic                  sx_q, sx_d, sd_q, sd_d;
  logic [OW-1:0]         quot_q, quot_d;
  logic [IW-1:0]         rem_q, rem_d;
  logic                  dbz_q, dbz_d, apx_q, apx_d;

  // Magnitudes are unsigned, so |-2^(W-1)| still fits in W bits.
  logic [OW-1:0]         x_abs;
  logic [IW-1:0]         d_abs;
  logic [N_BIT_APPR-1:0] k_cl;
  logic [IW:0]           r_sh;
  logic                  ge;
  logic [OW-1:0]         qmag;
  logic [IW-1:0]         rmag;

  assign x_abs = dividend[OW-1] ? -dividend : dividend;
  assign d_abs = divisor[IW-1]  ? -divisor  : divisor;
  assign k_cl  = (appr_lsb > N_BIT_APPR'(MAX_APPR)) ? N_BIT_APPR'(MAX_APPR) : appr_lsb;
  assign r_sh  = {r_q[IW-1:0], xsr_q[OW-1]};
  assign ge    = (r_sh >= {1'b0, dmag_q});
  assign qmag  = qr_q << k_q;
  assign rmag  = r_q[IW-1:0];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign approx    = apx_q;

  always_comb begin
    state_d = state_q;
    xsr_d   = xsr_q;
    qr_d    = qr_q;
    dmag_d  = dmag_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    sx_d    = sx_q;
    sd_d    = sd_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    apx_d   = apx_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        if (divisor == '0) begin
          quot_d  = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          apx_d   = 1'b0;
          state_d = DONE;
        end else if (dividend == '0) begin
          quot_d  = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          apx_d   = 1'b0;
          state_d = DONE;
        end else begin
          xsr_d   = x_abs;
          dmag_d  = d_abs;
          r_d     = '0;
          qr_d    = '0;
          k_d     = k_cl;
          cnt_d   = CW'(OW) - CW'(k_cl);
          sx_d    = dividend[OW-1];
          sd_d    = divisor[IW-1];
          state_d = CALC;
        end
      end
      CALC: begin
        r_d   = ge ? (r_sh - {1'b0, dmag_q}) : r_sh;
        qr_d  = {qr_q[OW-2:0], ge};
        xsr_d = xsr_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = (sx_q ^ sd_q) ? -qmag : qmag;
        rem_d   = sx_q ? -rmag : rmag;
        dbz_d   = 1'b0;
        apx_d   = (k_q != '0);
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xsr_q   <= '0;
      qr_q    <= '0;
      dmag_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      sx_q    <= 1'b0;
      sd_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      apx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xsr_q   <= xsr_d;
      qr_q    <= qr_d;
      dmag_q  <= dmag_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      sx_q    <= sx_d;
      sd_q    <= sd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      apx_q   <= apx_d;
    end
  end
endmodule

// File: tb/tb_div_18x9_signed_seq.sv
// Directed and random bench for the signed divider, scoreboard of expected results.
module tb_div_18x9_signed_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, dbz, approx;
  logic [17:0] dividend, quotient;
  logic [8:0]  divisor, remainder;
  logic [3:0]  appr_lsb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [17:0] q;
    logic [8:0]  r;
    logic        dz;
    logic        ap;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_18x9_signed_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .appr_lsb(appr_lsb),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .dbz(dbz), .approx(approx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: truncating division on |x|>>k, quotient rescaled by <<k.
  task automatic model(input int x, input int d, input int k, output exp_t e);
    int kk, ax, ad, qm, rm, qs, rs;
    kk = (k > 8) ? 8 : k;
    if (d == 0) begin
      e.q = 18'h3FFFF; e.r = '0; e.dz = 1'b1; e.ap = 1'b0; e.lat = 1;
    end else if (x == 0) begin
      e.q = '0; e.r = '0; e.dz = 1'b0; e.ap = 1'b0; e.lat = 1;
    end else begin
      ax = (x < 0) ? -x : x;
      ad = (d < 0) ? -d : d;
      qm = (ax >>> kk) / ad;
      rm = (ax >>> kk) % ad;
      qs = ((x < 0) != (d < 0)) ? -(qm << kk) : (qm << kk);
      rs = (x < 0) ? -rm : rm;
      e.q = qs[17:0]; e.r = rs[8:0]; e.dz = 1'b0; e.ap = (kk != 0); e.lat = 20 - kk;
    end
  endtask

  // Drive one operation, then scramble inputs to prove they were captured at accept.
  task automatic drive(input logic [17:0] x, input logic [8:0] d, input logic [3:0] k);
    dividend = x; divisor = d; appr_lsb = k; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 18'($urandom); divisor = 9'($urandom); appr_lsb = 4'($urandom);
  endtask

  // Waits for out_valid at a negedge; returns edges counted from the accept edge.
  task automatic wait_out(output int lat, output bit ok);
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [17:0] x, input logic [8:0] d,
                        input logic [3:0] k, input exp_t e);
    exp_t got;
    int   lat;
    bit   ok;
    sb.push_back(e);
    drive(x, d, k);
    wait_out(lat, ok);
    got = sb.pop_front();
    if (!ok) begin
      chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({tag, "_q"},   32'(quotient),  32'(got.q));
    chk({tag, "_r"},   32'(remainder), 32'(got.r));
    chk({tag, "_dbz"}, 32'(dbz),       32'(got.dz));
    chk({tag, "_apx"}, 32'(approx),    32'(got.ap));
    chk({tag, "_lat"}, 32'(lat),       32'(got.lat));
    @(posedge clk); #1;
  endtask

  function automatic exp_t mk(logic [17:0] q, logic [8:0] r, logic dz, logic ap, int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ap = ap; e.lat = lat;
    return e;
  endfunction

  initial begin
    exp_t e;
    int   lat;
    bit   ok;
    logic [17:0] qhold;
    logic [17:0] rx;
    logic [8:0]  rd;
    logic [3:0]  rk;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; appr_lsb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q",         32'(quotient),  32'd0);
    chk("rst_r",         32'(remainder), 32'd0);
    chk("rst_dbz",       32'(dbz),       32'd0);
    chk("rst_apx",       32'(approx),    32'd0);
    @(posedge clk); #1;

    run_op("pp",    18'd1000,        9'd7,   4'd0,  mk(18'd142,      9'd6,      0, 0, 20));
    run_op("np",    -18'sd1000,      9'd7,   4'd0,  mk(-18'sd142,    -9'sd6,    0, 0, 20));
    run_op("pn",    18'd1000,        -9'sd7, 4'd0,  mk(-18'sd142,    9'd6,      0, 0, 20));
    run_op("nn",    -18'sd1000,      -9'sd7, 4'd0,  mk(18'd142,      -9'sd6,    0, 0, 20));
    run_op("dbz",   18'd500,         9'd0,   4'd0,  mk(18'h3FFFF,    9'd0,      1, 0, 1));
    run_op("zero",  18'd0,           9'd5,   4'd0,  mk(18'd0,        9'd0,      0, 0, 1));
    run_op("ovf",   18'h20000,       -9'sd1, 4'd0,  mk(18'h20000,    9'd0,      0, 0, 20));
    run_op("m256",  18'd131071,      9'h100, 4'd0,  mk(-18'sd511,    9'd255,    0, 0, 20));
    run_op("k4",    18'd1000,        9'd7,   4'd4,  mk(18'd128,      9'd6,      0, 1, 16));
    run_op("k15",   18'd1000,        9'd7,   4'd15, mk(18'd0,        9'd3,      0, 1, 12));
    run_op("small", -18'sd5,         9'd9,   4'd0,  mk(18'd0,        -9'sd5,    0, 0, 20));

    // Backpressure: DONE must hold steady while out_ready is low.
    out_ready = 1'b0;
    drive(-18'sd1000, -9'sd7, 4'd0);
    wait_out(lat, ok);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_q",     32'(quotient),  32'd142);
    qhold = quotient;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_rdy",   32'(in_ready),  32'd0);
      chk("bp_hold_q",     32'(quotient),  32'(qhold));
      chk("bp_hold_r",     32'(remainder), 32'h1FA);
    end
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_rdy",   32'(in_ready),  32'd1);
    chk("bp_rel_q",     32'(quotient),  32'd142);
    @(posedge clk); #1;

    // Reset during the fifth CALC cycle discards the operation.
    drive(18'd1000, 9'd7, 4'd0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy",   32'(in_ready),  32'd1);
    @(posedge clk); #1;
    run_op("post_rst", 18'd2000, 9'd13, 4'd0, mk(18'd153, 9'd11, 0, 0, 20));

    for (int n = 0; n < 24; n++) begin
      rx = 18'($urandom);
      rd = (n % 6 == 5) ? 9'd0 : 9'($urandom);
      rk = 4'($urandom_range(0, 15));
      model(int'($signed(rx)), int'($signed(rd)), int'(rk), e);
      run_op("rand", rx, rd, rk, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
